// File: rtl/mura_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : mura_pkg                                                   |
// | Purpose  : Shared encodings and helpers for the mod-3 step automaton. |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
package mura_pkg;

    typedef logic [1:0] mura_state_t;

    localparam mura_state_t S0 = 2'd0;
    localparam mura_state_t S1 = 2'd1;
    localparam mura_state_t S2 = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } stepper_state_t;

    function automatic mura_state_t mura_next(input mura_state_t s);
        return (s == S2) ? S0 : mura_state_t'(s + 2'd1);
    endfunction

    // Forward distance from one counter state to another, in steps (0..2).
    function automatic logic [1:0] mura_dist(input mura_state_t from, input mura_state_t to);
        logic [2:0] d;
        d = {1'b0, to} + 3'd3 - {1'b0, from};
        if (d >= 3'd3) begin
            d = d - 3'd3;
        end
        return d[1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mura_model.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : mura_model                                                 |
// | Purpose  : Local replica of the mod-3 Moore counter being driven.     |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module mura_model
    import mura_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_step,
    output mura_state_t o_state,
    output logic        o_y
);

    mura_state_t r_state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S0;
        end else if (i_step) begin
            r_state <= mura_next(r_state);
        end
    end

    assign o_state = r_state;
    assign o_y     = (r_state != S0);

endmodule
`default_nettype wire

// File: rtl/mura_stepper.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : mura_stepper                                               |
// | Purpose  : Drives en/a step pulses to move a mod-3 counter to target. |
// |            Optional y checker: define MURA_STEPPER_CHECK_EN.          |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module mura_stepper
    import mura_pkg::*;
#(
    parameter int GAP = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [1:0] req_target,
    output logic       req_ready,
    output logic       en_o,
    output logic       a_o,
    input  logic       y_i,
    output logic [1:0] model_state_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       bad_o,
    output logic       err_o
);

    localparam bit c_HAS_GAP = (GAP > 0);
    localparam int c_GW      = c_HAS_GAP ? $clog2(GAP + 1) : 1;

    stepper_state_t  r_state;
    logic [1:0]      r_n;
    logic [c_GW-1:0] r_gap;
    logic            r_en;
    logic            r_busy;
    logic            r_done;
    logic            r_bad;
    logic            r_ready;

    mura_state_t     w_model_state;
    logic            w_model_y;
    logic [1:0]      w_dist;
    logic            w_accept;

    assign w_dist   = mura_dist(w_model_state, req_target);
    assign w_accept = req_valid && r_ready;

    // The model steps on the same edge that ends each pulse, mirroring the counter.
    mura_model u_model (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_step  (r_en),
        .o_state (w_model_state),
        .o_y     (w_model_y)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_n     <= 2'd0;
            r_gap   <= '0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_bad   <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_en   <= 1'b0;
            r_done <= 1'b0;
            r_bad  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_busy  <= 1'b1;
                        r_ready <= 1'b0;
                        if (req_target == 2'd3) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_bad   <= 1'b1;
                        end else if (w_dist == 2'd0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_STEP;
                            r_n     <= w_dist;
                            r_en    <= 1'b1;
                        end
                    end
                end
                ST_STEP: begin
                    r_n <= r_n - 2'd1;
                    if (r_n == 2'd1) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else if (c_HAS_GAP) begin
                        r_state <= ST_GAP;
                        r_gap   <= c_GW'(GAP);
                    end else begin
                        r_state <= ST_STEP;
                        r_en    <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_gap == c_GW'(1)) begin
                        r_state <= ST_STEP;
                        r_en    <= 1'b1;
                    end else begin
                        r_gap <= r_gap - c_GW'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef MURA_STEPPER_CHECK_EN
    logic r_err;

    // The counter's y is compared once per request, when the model is final.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (r_state == ST_IDLE && w_accept) begin
            r_err <= 1'b0;
        end else if (r_state == ST_DONE && (y_i != w_model_y)) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`else
    logic w_unused;
    assign w_unused = &{1'b0, y_i, w_model_y};
    assign err_o    = 1'b0;
`endif

    assign req_ready     = r_ready;
    assign en_o          = r_en;
    assign a_o           = r_en;
    assign model_state_o = w_model_state;
    assign busy_o        = r_busy;
    assign done_o        = r_done;
    assign bad_o         = r_bad;

endmodule
`default_nettype wire

// File: tb/tb_mura_stepper.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_mura_stepper                                            |
// | Purpose  : Scoreboard bench for mura_stepper at GAP=1 and GAP=0.      |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module tb_mura_stepper;

    typedef struct {
        logic       en;
        logic       done;
        logic       bad;
        logic       ready;
        logic       busy;
        logic       err;
        logic [1:0] model;
        logic [1:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid  [2];
    logic [1:0] target [2];
    logic       ready  [2];
    logic       en     [2];
    logic       a      [2];
    logic       busy   [2];
    logic       done   [2];
    logic       bad    [2];
    logic       err    [2];
    logic [1:0] model  [2];
    logic       y_in   [2];
    logic       yovr   [2];
    logic [1:0] cnt    [2];

    int         checks = 0;
    int         errors = 0;
    logic [1:0] sm   [2];
    logic       xerr [2];
    exp_t       q [$];

    always #5 clk = ~clk;

    // Behavioural mod-3 Moore counter on the far side of each link.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n)
                cnt[i] <= 2'd0;
            else if (en[i] && a[i])
                cnt[i] <= (cnt[i] == 2'd2) ? 2'd0 : cnt[i] + 2'd1;
        end
    end

    assign y_in[0] = yovr[0] ? 1'b0 : (cnt[0] != 2'd0);
    assign y_in[1] = yovr[1] ? 1'b0 : (cnt[1] != 2'd0);

    mura_stepper #(.GAP(1)) u_dut_g1 (
        .clk(clk), .rst_n(rst_n), .req_valid(valid[0]), .req_target(target[0]),
        .req_ready(ready[0]), .en_o(en[0]), .a_o(a[0]), .y_i(y_in[0]),
        .model_state_o(model[0]), .busy_o(busy[0]), .done_o(done[0]),
        .bad_o(bad[0]), .err_o(err[0])
    );

    mura_stepper #(.GAP(0)) u_dut_g0 (
        .clk(clk), .rst_n(rst_n), .req_valid(valid[1]), .req_target(target[1]),
        .req_ready(ready[1]), .en_o(en[1]), .a_o(a[1]), .y_i(y_in[1]),
        .model_state_o(model[1]), .busy_o(busy[1]), .done_o(done[1]),
        .bad_o(bad[1]), .err_o(err[1])
    );

    function automatic int gap_of(input int d);
        return (d == 0) ? 1 : 0;
    endfunction

    task automatic chk(input string tag, input int d, input logic [1:0] obs, input logic [1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s dut%0d observed=%0d expected=%0d", tag, d, obs, expv);
        end
    endtask

    task automatic chk_idle(input string tag, input int d, input logic [1:0] m);
        chk({tag, "_en"}, d, {1'b0, en[d]}, 2'd0);
        chk({tag, "_a"}, d, {1'b0, a[d]}, 2'd0);
        chk({tag, "_busy"}, d, {1'b0, busy[d]}, 2'd0);
        chk({tag, "_done"}, d, {1'b0, done[d]}, 2'd0);
        chk({tag, "_bad"}, d, {1'b0, bad[d]}, 2'd0);
        chk({tag, "_ready"}, d, {1'b0, ready[d]}, 2'd1);
        chk({tag, "_model"}, d, model[d], m);
        chk({tag, "_cnt"}, d, cnt[d], m);
    endtask

    task automatic run_req(input int d, input logic [1:0] tgt, input logic ovr);
        int         n;
        int         len;
        int         g;
        logic [1:0] m;
        exp_t       e;
        @(negedge clk);
        valid[d]  = 1'b1;
        target[d] = tgt;
        yovr[d]   = ovr;
        g = gap_of(d);
        m = sm[d];
        n = (tgt == 2'd3) ? 0 : (int'(tgt) + 3 - int'(m)) % 3;
        len = (n == 0) ? 1 : n + (n - 1) * g + 1;
        for (int c = 1; c <= len; c++) begin
            e.en    = (n > 0) && (c < len) && (((c - 1) % (g + 1)) == 0);
            e.done  = (c == len);
            e.bad   = (c == len) && (tgt == 2'd3);
            e.ready = 1'b0;
            e.busy  = 1'b1;
            e.err   = 1'b0;
            e.model = m;
            e.cnt   = m;
            q.push_back(e);
            if (e.en) m = (m == 2'd2) ? 2'd0 : m + 2'd1;
        end
        e.en    = 1'b0;
        e.done  = 1'b0;
        e.bad   = 1'b0;
        e.ready = 1'b1;
        e.busy  = 1'b0;
`ifdef MURA_STEPPER_CHECK_EN
        e.err   = ovr && (m != 2'd0);
`else
        e.err   = 1'b0;
`endif
        e.model = m;
        e.cnt   = m;
        q.push_back(e);
        sm[d]   = m;
        xerr[d] = e.err;
        @(posedge clk);
        while (q.size() > 0) begin
            @(negedge clk);
            e = q.pop_front();
            chk("en", d, {1'b0, en[d]}, {1'b0, e.en});
            chk("a", d, {1'b0, a[d]}, {1'b0, e.en});
            chk("done", d, {1'b0, done[d]}, {1'b0, e.done});
            chk("bad", d, {1'b0, bad[d]}, {1'b0, e.bad});
            chk("ready", d, {1'b0, ready[d]}, {1'b0, e.ready});
            chk("busy", d, {1'b0, busy[d]}, {1'b0, e.busy});
            chk("err", d, {1'b0, err[d]}, {1'b0, e.err});
            chk("model", d, model[d], e.model);
            chk("cnt", d, cnt[d], e.cnt);
            target[d] = ~tgt;
            if (e.done) valid[d] = 1'b0;
        end
        yovr[d] = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            valid[i]  = 1'b0;
            target[i] = 2'd0;
            yovr[i]   = 1'b0;
            sm[i]     = 2'd0;
            xerr[i]   = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk_idle("rst", i, 2'd0);
            chk("rst_err", i, {1'b0, err[i]}, 2'd0);
        end
        rst_n = 1'b1;

        run_req(0, 2'd2, 1'b0);
        run_req(0, 2'd1, 1'b0);
        run_req(0, 2'd1, 1'b0);
        run_req(0, 2'd3, 1'b0);
        run_req(1, 2'd2, 1'b0);
        run_req(1, 2'd1, 1'b0);
        run_req(1, 2'd3, 1'b0);
        run_req(1, 2'd0, 1'b0);
        run_req(0, 2'd0, 1'b0);

        // Counter y forced low while the model lands on S2.
        run_req(0, 2'd2, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("err_hold", 0, {1'b0, err[0]}, {1'b0, xerr[0]});
            chk("err_hold_ready", 0, {1'b0, ready[0]}, 2'd1);
        end
        run_req(0, 2'd2, 1'b0);

        // Reset asserted during the first pulse of a two-step request.
        @(negedge clk);
        valid[0]  = 1'b1;
        target[0] = 2'd1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_pre_en", 0, {1'b0, en[0]}, 2'd1);
        valid[0] = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        chk_idle("rst_mid", 0, 2'd0);
        chk_idle("rst_mid", 1, 2'd0);
        chk("rst_mid_err", 0, {1'b0, err[0]}, 2'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sm[i]   = 2'd0;
            xerr[i] = 1'b0;
        end

        run_req(0, 2'd2, 1'b0);
        run_req(1, 2'd1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
